sparse_systolic_tile: RTL and testbench

- Weight-stationary N_ROWS x N_COLS MAC tile with an integrated control FSM.
- Phases: load weights → stream K activation beats → flush the pipeline → drain the accumulators row by row.
- All transfers use valid/ready handshakes.
- Unlike a globally gated array, each activation beat carries its own sparse skip tag. The tag travels with the data through the skew and column pipelines, so skipped beats gate exactly the PEs they reach.
- Sits between the block scheduler/act/wgt buffers and the output accumulator writeback.

---
 rtl/sparse_systolic_tile_pkg.sv | 30 +++
 rtl/sparse_systolic_tile_if.sv | 55 +++++
 rtl/sparse_systolic_tile_pe.sv | 46 ++++
 rtl/sparse_systolic_tile.sv | 166 ++++++++++++++++
 tb/tb_sparse_systolic_tile.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sparse_systolic_tile_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sparse_tile_pkg : state encoding and sizing helpers for the tile
// Rev 1.0
// ------------------------------------------------------------------
package sparse_tile_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    FLUSH   = 3'd3,
    DRAIN   = 3'd4
  } tile_state_e;

  localparam int TILE_N_ROWS = 16;
  localparam int TILE_N_COLS = 16;
  localparam int ROW_IDX_W   = $clog2(TILE_N_ROWS);
  localparam int FLUSH_CYC   = TILE_N_ROWS + TILE_N_COLS;

  function automatic int row_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int flush_cyc(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sparse_systolic_tile_if.sv
`default_nettype none
// ------------------------------------------------------------------
// sparse_systolic_tile_if : control, weight, activation and output
// handshake bundle of the tile.  Rev 1.0
// ------------------------------------------------------------------
interface sparse_systolic_tile_if #(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 16
) ();
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  logic                     start;
  logic [K_W-1:0]           cfg_k;
  logic                     wgt_valid;
  logic                     wgt_ready;
  logic [N_COLS*DATA_W-1:0] wgt_data;
  logic                     act_valid;
  logic                     act_ready;
  logic [N_ROWS*DATA_W-1:0] act_data;
  logic                     act_block_valid;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_COLS*ACC_W-1:0]  out_data;
  logic [ROW_W-1:0]         out_row;
  logic                     busy;
  logic                     done;
`ifdef SPARSE_SKIP_STATS_EN
  logic [K_W-1:0]           skip_cnt;
`endif

  modport slave (
    input  start, cfg_k, wgt_valid, wgt_data, act_valid, act_data,
           act_block_valid, out_ready,
    output
`ifdef SPARSE_SKIP_STATS_EN
           skip_cnt,
`endif
           wgt_ready, act_ready, out_valid, out_data, out_row, busy, done
  );

  modport master (
    output start, cfg_k, wgt_valid, wgt_data, act_valid, act_data,
           act_block_valid, out_ready,
    input
`ifdef SPARSE_SKIP_STATS_EN
           skip_cnt,
`endif
           wgt_ready, act_ready, out_valid, out_data, out_row, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/sparse_systolic_tile_pe.sv
`default_nettype none
// ------------------------------------------------------------------
// sparse_tile_pe : weight-stationary PE with tag-gated signed MAC
// Rev 1.0
// ------------------------------------------------------------------
module sparse_tile_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wgt_en,
  input  logic [DATA_W-1:0] wgt_in,
  input  logic              acc_clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic              tag_in,
  output logic [DATA_W-1:0] a_out,
  output logic              tag_out,
  output logic [ACC_W-1:0]  acc
);

  logic [DATA_W-1:0]          wgt;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = $signed(a_in) * $signed(wgt);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgt     <= '0;
      a_out   <= '0;
      tag_out <= 1'b0;
      acc     <= '0;
    end else begin
      if (wgt_en) wgt <= wgt_in;
      a_out   <= a_in;
      tag_out <= tag_in;
      // clear wins: it only fires at end of LOAD, when no tagged beat is in flight
      if (acc_clr)     acc <= '0;
      else if (tag_in) acc <= acc + prod_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sparse_systolic_tile.sv
`default_nettype none
// ------------------------------------------------------------------
// sparse_systolic_tile : weight-stationary MAC tile with per-beat skip
// tags; optional SPARSE_SKIP_STATS_EN adds skip_cnt.  Rev 1.0
// ------------------------------------------------------------------
module sparse_systolic_tile
  import sparse_tile_pkg::*;
#(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sparse_systolic_tile_if.slave bus
);

  localparam int RIDX_W  = row_idx_w(N_ROWS);
  localparam int FLUSH_N = flush_cyc(N_ROWS, N_COLS);
  localparam int FCNT_W  = $clog2(FLUSH_N + 1);
  localparam logic [RIDX_W-1:0] LAST_ROW   = RIDX_W'(N_ROWS - 1);
  localparam logic [FCNT_W-1:0] LAST_FLUSH = FCNT_W'(FLUSH_N - 1);

  tile_state_e       state, state_nxt;
  logic [RIDX_W-1:0] load_ptr;
  logic [RIDX_W-1:0] out_row;
  logic [K_W-1:0]    k_cfg;
  logic [K_W-1:0]    beat_cnt;
  logic [FCNT_W-1:0] flush_cnt;

  logic start_hs, wgt_hs, act_hs, out_hs;
  logic load_last, beat_last, flush_last, drain_last;

  assign start_hs   = (state == IDLE)    && bus.start;
  assign wgt_hs     = (state == LOAD)    && bus.wgt_valid;
  assign act_hs     = (state == COMPUTE) && bus.act_valid;
  assign out_hs     = (state == DRAIN)   && bus.out_ready;
  assign load_last  = wgt_hs && (load_ptr == LAST_ROW);
  assign beat_last  = act_hs && (beat_cnt == k_cfg - K_W'(1));
  assign flush_last = (state == FLUSH) && (flush_cnt == LAST_FLUSH);
  assign drain_last = out_hs && (out_row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_hs)   state_nxt = LOAD;
      LOAD:    if (load_last)  state_nxt = (k_cfg == '0) ? FLUSH : COMPUTE;
      COMPUTE: if (beat_last)  state_nxt = FLUSH;
      FLUSH:   if (flush_last) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.wgt_ready = (state == LOAD);
    bus.act_ready = (state == COMPUTE);
    bus.out_valid = (state == DRAIN);
    bus.busy      = (state != IDLE);
    bus.done      = drain_last;
    bus.out_row   = out_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_cfg     <= '0;
      load_ptr  <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      out_row   <= '0;
    end else begin
      if (start_hs) begin
        k_cfg    <= bus.cfg_k;
        load_ptr <= '0;
        out_row  <= '0;
      end else begin
        if (wgt_hs) load_ptr <= load_ptr + RIDX_W'(1);
        if (out_hs) out_row  <= drain_last ? '0 : out_row + RIDX_W'(1);
      end
      if (load_last)   beat_cnt <= '0;
      else if (act_hs) beat_cnt <= beat_cnt + K_W'(1);
      flush_cnt <= (state == FLUSH) ? flush_cnt + FCNT_W'(1) : '0;
    end
  end

  logic [DATA_W-1:0] a_h   [N_ROWS][N_COLS+1];
  logic              tag_h [N_ROWS][N_COLS+1];
  logic [ACC_W-1:0]  acc   [N_ROWS][N_COLS];

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    // stage 0 captures the beat, stages 1..r skew row r by r cycles
    logic [DATA_W-1:0] sk_a [r+1];
    logic              sk_t [r+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= r; i++) begin
          sk_a[i] <= '0;
          sk_t[i] <= 1'b0;
        end
      end else begin
        sk_a[0] <= bus.act_data[r*DATA_W +: DATA_W];
        sk_t[0] <= act_hs && bus.act_block_valid;
        for (int i = 1; i <= r; i++) begin
          sk_a[i] <= sk_a[i-1];
          sk_t[i] <= sk_t[i-1];
        end
      end
    end

    assign a_h[r][0]   = sk_a[r];
    assign tag_h[r][0] = sk_t[r];

    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      sparse_tile_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .wgt_en  (wgt_hs && (load_ptr == RIDX_W'(r))),
        .wgt_in  (bus.wgt_data[c*DATA_W +: DATA_W]),
        .acc_clr (load_last),
        .a_in    (a_h[r][c]),
        .tag_in  (tag_h[r][c]),
        .a_out   (a_h[r][c+1]),
        .tag_out (tag_h[r][c+1]),
        .acc     (acc[r][c])
      );
    end
  end

  always_comb begin
    bus.out_data = '0;
    if (state == DRAIN) begin
      for (int c = 0; c < N_COLS; c++) begin
        bus.out_data[c*ACC_W +: ACC_W] = acc[out_row][c];
      end
    end
  end

`ifdef SPARSE_SKIP_STATS_EN
  logic [K_W-1:0] skip_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      skip_cnt <= '0;
    else if (start_hs)
      skip_cnt <= '0;
    else if (act_hs && !bus.act_block_valid && (skip_cnt != '1))
      skip_cnt <= skip_cnt + K_W'(1);
  end

  assign bus.skip_cnt = skip_cnt;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_sparse_systolic_tile.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sparse_systolic_tile : directed vectors on a 4x4 tile, run on a
// 32-bit and a 16-bit accumulator instance in parallel.  Rev 1.0
// ------------------------------------------------------------------
module tb_sparse_systolic_tile;

  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int DW  = 8;
  localparam int KW  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [KW-1:0]  cfg_k;
  logic           wgt_valid;
  logic [31:0]    wgt_data;
  logic           act_valid;
  logic [31:0]    act_data;
  logic           act_blk;
  logic           out_ready;

  int n_vec  = 0;
  int n_miss = 0;

  logic [127:0] exp32 [4];
  logic [63:0]  exp16 [4];

  always #5 clk = ~clk;

  sparse_systolic_tile_if #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(32), .K_W(KW)) bus32 ();
  sparse_systolic_tile_if #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(16), .K_W(KW)) bus16 ();

  assign bus32.start = start;            assign bus16.start = start;
  assign bus32.cfg_k = cfg_k;            assign bus16.cfg_k = cfg_k;
  assign bus32.wgt_valid = wgt_valid;    assign bus16.wgt_valid = wgt_valid;
  assign bus32.wgt_data = wgt_data;      assign bus16.wgt_data = wgt_data;
  assign bus32.act_valid = act_valid;    assign bus16.act_valid = act_valid;
  assign bus32.act_data = act_data;      assign bus16.act_data = act_data;
  assign bus32.act_block_valid = act_blk; assign bus16.act_block_valid = act_blk;
  assign bus32.out_ready = out_ready;    assign bus16.out_ready = out_ready;

  sparse_systolic_tile #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(32), .K_W(KW))
    dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  sparse_systolic_tile #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .ACC_W(16), .K_W(KW))
    dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [KW-1:0] k);
    start = 1'b1;
    cfg_k = k;
    tick();
    start = 1'b0;
  endtask

  task automatic load_weights(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int r = 0; r < 4; r++) begin
      int n = 0;
      wgt_valid = 1'b1;
      wgt_data  = w[r];
      while (!bus32.wgt_ready && n < 50) begin tick(); n++; end
      if (n >= 50) check_val("wgt_ready_wait", 1'b0, 1'b1);
      tick();
    end
    wgt_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic tag, input int gap,
                           input bit pulse_start);
    int n = 0;
    act_valid = 1'b1;
    act_data  = a;
    act_blk   = tag;
    if (pulse_start) begin
      start = 1'b1;
      cfg_k = 16'd5;
    end
    while (!bus32.act_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check_val("act_ready_wait", 1'b0, 1'b1);
    tick();
    start     = 1'b0;
    act_valid = 1'b0;
    if (pulse_start) check_val("busy_after_ignored_start", bus32.busy, 1'b1);
    repeat (gap) tick();
  endtask

  task automatic drain(input int stall_row, input int stall_n);
    int n = 0;
    out_ready = 1'b1;
    while (!bus32.out_valid && n < 200) begin tick(); n++; end
    check_val("out_valid_rise", bus32.out_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_row) begin
        out_ready = 1'b0;
        repeat (stall_n) tick();
        check_val("stall_out_valid", bus32.out_valid, 1'b1);
        check_val("stall_out_row", bus32.out_row, i);
        check_val("stall_out_data", bus32.out_data, exp32[i]);
        check_val("stall_done", bus32.done, 1'b0);
        out_ready = 1'b1;
      end
      #1;
      check_val("out_row", bus32.out_row, i);
      check_val("out_data32", bus32.out_data, exp32[i]);
      check_val("out_data16", bus16.out_data, exp16[i]);
      check_val("done", bus32.done, (i == 3));
      tick();
    end
    check_val("out_valid_after", bus32.out_valid, 1'b0);
    check_val("busy_after", bus32.busy, 1'b0);
  endtask

  task automatic set_exp(input logic [127:0] e0, input logic [127:0] e1,
                         input logic [127:0] e2, input logic [127:0] e3,
                         input logic [63:0] f0, input logic [63:0] f1,
                         input logic [63:0] f2, input logic [63:0] f3);
    exp32[0] = e0; exp32[1] = e1; exp32[2] = e2; exp32[3] = e3;
    exp16[0] = f0; exp16[1] = f1; exp16[2] = f2; exp16[3] = f3;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_busy"},      bus32.busy, 1'b0);
    check_val({tag, "_wgt_ready"}, bus32.wgt_ready, 1'b0);
    check_val({tag, "_act_ready"}, bus32.act_ready, 1'b0);
    check_val({tag, "_out_valid"}, bus32.out_valid, 1'b0);
    check_val({tag, "_done"},      bus32.done, 1'b0);
    check_val({tag, "_out_row"},   bus32.out_row, 2'd0);
    check_val({tag, "_out_data"},  bus32.out_data, 128'd0);
`ifdef SPARSE_SKIP_STATS_EN
    check_val({tag, "_skip_cnt"},  bus32.skip_cnt, 16'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_k = '0; wgt_valid = 1'b0; wgt_data = '0;
    act_valid = 1'b0; act_data = '0; act_blk = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    // identity weights, one beat {4,3,2,1}
    start_tile(16'd1);
    load_weights(32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000);
    send_beat(32'h04030201, 1'b1, 0, 1'b0);
    set_exp(128'h00000000_00000000_00000000_00000001,
            128'h00000000_00000000_00000002_00000000,
            128'h00000000_00000003_00000000_00000000,
            128'h00000004_00000000_00000000_00000000,
            64'h0000_0000_0000_0001, 64'h0000_0000_0002_0000,
            64'h0000_0003_0000_0000, 64'h0004_0000_0000_0000);
    drain(-1, 0);

    // all beats skipped
    start_tile(16'd3);
    load_weights(32'h05050505, 32'h05050505, 32'h05050505, 32'h05050505);
    for (int b = 0; b < 3; b++) send_beat(32'h07070707, 1'b0, 0, 1'b0);
    set_exp('0, '0, '0, '0, '0, '0, '0, '0);
    drain(-1, 0);
`ifdef SPARSE_SKIP_STATS_EN
    check_val("skip_cnt_all_skip", bus32.skip_cnt, 16'd3);
`endif

    // 127*127 x8 with bubbles between beats, backpressure on row 1
    start_tile(16'd8);
    load_weights(32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f);
    for (int b = 0; b < 8; b++) send_beat(32'h7f7f7f7f, 1'b1, 1, 1'b0);
    set_exp({4{32'h0001F808}}, {4{32'h0001F808}}, {4{32'h0001F808}}, {4{32'h0001F808}},
            {4{16'hF808}}, {4{16'hF808}}, {4{16'hF808}}, {4{16'hF808}});
    drain(1, 5);

    // -128*-128 x2: 32768, wraps to -32768 in 16 bits
    start_tile(16'd2);
    load_weights(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080);
    for (int b = 0; b < 2; b++) send_beat(32'h80808080, 1'b1, 0, 1'b0);
    set_exp({4{32'h00008000}}, {4{32'h00008000}}, {4{32'h00008000}}, {4{32'h00008000}},
            {4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}});
    drain(-1, 0);

    // negative activation, second beat skipped, start pulse mid-COMPUTE ignored
    start_tile(16'd2);
    load_weights(32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201);
    send_beat(32'hFFFFFFFF, 1'b1, 0, 1'b0);
    send_beat(32'h02020202, 1'b0, 0, 1'b1);
    set_exp({4{128'hFFFFFFFC_FFFFFFFD_FFFFFFFE_FFFFFFFF}} , 128'hFFFFFFFC_FFFFFFFD_FFFFFFFE_FFFFFFFF,
            128'hFFFFFFFC_FFFFFFFD_FFFFFFFE_FFFFFFFF, 128'hFFFFFFFC_FFFFFFFD_FFFFFFFE_FFFFFFFF,
            64'hFFFC_FFFD_FFFE_FFFF, 64'hFFFC_FFFD_FFFE_FFFF,
            64'hFFFC_FFFD_FFFE_FFFF, 64'hFFFC_FFFD_FFFE_FFFF);
    drain(-1, 0);
`ifdef SPARSE_SKIP_STATS_EN
    check_val("skip_cnt_mixed", bus32.skip_cnt, 16'd1);
`endif

    // cfg_k=0: straight to FLUSH, accumulators cleared
    start_tile(16'd0);
    load_weights(32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111);
    check_val("k0_act_ready", bus32.act_ready, 1'b0);
    check_val("k0_busy", bus32.busy, 1'b1);
    set_exp('0, '0, '0, '0, '0, '0, '0, '0);
    drain(-1, 0);

    // reset mid-COMPUTE, then a clean tile
    start_tile(16'd4);
    load_weights(32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000);
    send_beat(32'h09090909, 1'b1, 0, 1'b0);
    send_beat(32'h09090909, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    start_tile(16'd1);
    load_weights(32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000);
    send_beat(32'h0A0B0C0D, 1'b1, 0, 1'b0);
    set_exp(128'h00000000_00000000_00000000_0000000D,
            128'h00000000_00000000_0000000C_00000000,
            128'h00000000_0000000B_00000000_00000000,
            128'h0000000A_00000000_00000000_00000000,
            64'h0000_0000_0000_000D, 64'h0000_0000_000C_0000,
            64'h0000_000B_0000_0000, 64'h000A_0000_0000_0000);
    drain(-1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
